dice_matrix_scan_driver: RTL
============================

// Module: dice_matrix_scan_driver
// PURPOSE
//  Rolling-dice controller driving a 3x3 pip LED matrix via 6 pins (3 anode rows, 3 cathode cols).
//  Arbitrary pip patterns need row multiplexing: each row is scanned in turn with a blanking gap between rows.
//  A roll button animates the face, then settles on a final value. A direct load path shows a fixed face.
//  Sits between board button/switch inputs and the LED header pins.
// PARAMETERS
//  FACES         8      number of faces, values 0..FACES-1; legal range 2..10
//  SCAN_DIV      1000   clk cycles per row dwell (lit time), >=1
//  BLANK_CYCLES  8      clk cycles with all rows off before each row change, >=1
//  ROLL_STEP     50000  clk cycles between face changes while rolling/settling, >=1
//  SETTLE_STEPS  5      face changes after roll_i release before settling, >=1
//  VW            $clog2(FACES)  value width (derived, not overridable)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  roll_i     in   1   roll request, level, already synchronised; high = keep rolling
//  load_i     in   1   one-cycle strobe: show value_i directly
//  value_i    in   VW  face to load; values >= FACES clamp to FACES-1
//  rows_o     out  3   row anodes, active-high; rows_o[0]=row1
//  cols_o     out  3   column cathodes, active-low; cols_o[0]=col1
//  value_o    out  VW  face currently displayed
//  rolling_o  out  1   high in ROLL or SETTLE
//  settled_o  out  1   one-cycle pulse when SETTLE completes
// BEHAVIOUR
//  Reset: rows_o=3'b000, cols_o=3'b111, value_o=0, rolling_o=0, settled_o=0, state SHOW.
//  Reset: scan row 0, phase BLANK, step counter 0. Reset mid-roll aborts immediately.
//  Pattern: segment index i=3*row+col; pips(v): 0 blank, 1 centre, 2..6 standard dice faces.
//  Pattern: 7 = six plus centre; 8 = all but centre; 9 = all. Lit pip = 1.
//  Scan: BLANK (BLANK_CYCLES, rows_o=0, cols_o=111) then LIT (SCAN_DIV).
//  LIT: rows_o=one-hot current row, cols_o=~pips(value_o)[row*3 +: 3]. Then next row, 2 wraps to 0.
//  Scan latency: a value_o change appears at most one row period later. No row is ever lit with a stale pattern mid-dwell.
//  The pattern is sampled at BLANK->LIT entry and held for the dwell.
//  FSM SHOW: roll_i=1 -> ROLL, step counter cleared.
//  FSM ROLL: every ROLL_STEP cycles value_o = (value_o==FACES-1) ? 0 : value_o+1.
//  FSM ROLL: roll_i=0 -> SETTLE with remaining=SETTLE_STEPS. The step counter is not cleared.
//  FSM SETTLE: same stepping; remaining decrements each step. When remaining reaches 0, the step that made it 0 is the final one.
//  FSM SETTLE: on the final step -> SHOW and settled_o pulses in that cycle. roll_i=1 in SETTLE -> back to ROLL.
//  load_i: in any state, load_i=1 -> value_o=min(value_i,FACES-1) next cycle, state SHOW, no settled_o.
//  load_i has priority over roll_i and over a coincident roll step.
//  If roll_i is still high after a load, the next cycle re-enters ROLL from the loaded value.
//  rolling_o is registered and equals (state!=SHOW).
//  Arithmetic: counters sized $clog2(max+1). All wrap logic is explicit compares, never power-of-2 overflow.
// STRUCTURE
//  Package dice_led_pkg: typedef enum {SHOW,ROLL,SETTLE} roll_state_t; typedef enum {BLANK,LIT} scan_phase_t.
//  Package dice_led_pkg: ROWS=3, COLS=3 constants; function pips(v) -> logic[8:0] (unused codes blank).
//  Sub-module led_matrix_scanner #(ROWS,COLS,SCAN_DIV,BLANK_CYCLES): takes a ROWS*COLS pattern, owns the scan counters and phase, drives rows_o/cols_o.
//  This module owns the roll FSM, step counter, value register and clamp logic.
// TESTING (FACES=8, SCAN_DIV=4, BLANK_CYCLES=2, ROLL_STEP=3, SETTLE_STEPS=2)
//  1. Reset asserted mid-LIT -> rows_o=000, cols_o=111, value_o=0 asynchronously. After release, first lit row comes 2 cycles later.
//  2. load_i, value_i=5 -> value_o=5.
//     Per row: row1 cols_o=010 (cols 1,3 lit); row2 cols_o=101 (centre); row3 cols_o=010.
//     Each lit 4 cycles, 2 blank cycles between rows.
//  3. value_i=7 with FACES=6 build -> value_o=5. value_i=9 with FACES=10 -> all nine cols low on every row.
//  4. From value 6, roll_i high 9 cycles -> value_o 7,0,1 on cycles 3,6,9 (wrap), rolling_o=1.
//     Then release -> 2 more steps, settled_o single pulse, value_o=3.
//  5. roll_i re-asserted during SETTLE -> no settled_o, stepping continues. load_i coincident with a step -> loaded value wins, state SHOW.
//  6. Free-run 10k cycles with random load/roll: check rows_o is one-hot or zero at all times.
//     Check rows_o=0 for exactly BLANK_CYCLES before every row change, and settled_o never pulses outside SETTLE->SHOW.

Source files
------------

// File: rtl/dice_led_pkg.sv
// Shared types and pip decoding for the dice LED matrix.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package dice_led_pkg;

    localparam int ROWS = 3;
    localparam int COLS = 3;

    typedef enum logic [1:0] {
        SHOW,
        ROLL,
        SETTLE
    } roll_state_t;

    typedef enum logic {
        BLANK,
        LIT
    } scan_phase_t;

    // Bit i lights segment i = 3*row + col; codes above 9 are blank.
    function automatic logic [8:0] pips(input logic [3:0] v);
        case (v)
            4'd1:    pips = 9'h010;
            4'd2:    pips = 9'h101;
            4'd3:    pips = 9'h111;
            4'd4:    pips = 9'h145;
            4'd5:    pips = 9'h155;
            4'd6:    pips = 9'h16D;
            4'd7:    pips = 9'h17D;
            4'd8:    pips = 9'h1EF;
            4'd9:    pips = 9'h1FF;
            default: pips = 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix scanner: blank gap, then one row lit for a fixed dwell.
// Latency: a pattern change is shown at the next BLANK->LIT entry (at most one row period).
// Backpressure: none; free-running, the row pattern is latched at LIT entry and held.
module led_matrix_scanner #(
    parameter int ROWS         = 3,
    parameter int COLS         = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS*COLS-1:0]   pattern_i,
    output logic [ROWS-1:0]        rows_o,
    output logic [COLS-1:0]        cols_o
);
    import dice_led_pkg::scan_phase_t;
    import dice_led_pkg::BLANK;
    import dice_led_pkg::LIT;

    localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    scan_phase_t     phase_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   row_q;
    logic [COLS-1:0] row_pat_q;
    logic [COLS-1:0] row_sel;
    logic            blank_done;
    logic            lit_done;

    assign blank_done = (cnt_q == CW'(BLANK_CYCLES - 1));
    assign lit_done   = (cnt_q == CW'(SCAN_DIV - 1));

    always_comb begin
        row_sel = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == RW'(r)) begin
                row_sel = pattern_i[r*COLS +: COLS];
            end
        end
    end

    // The row advances when its dwell ends, so every row change sits inside a blank gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= BLANK;
            cnt_q     <= '0;
            row_q     <= '0;
            row_pat_q <= '0;
        end else if (phase_q == BLANK) begin
            if (blank_done) begin
                phase_q   <= LIT;
                cnt_q     <= '0;
                row_pat_q <= row_sel;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            if (lit_done) begin
                phase_q <= BLANK;
                cnt_q   <= '0;
                row_q   <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        rows_o = '0;
        cols_o = '1;
        if (phase_q == LIT) begin
            for (int r = 0; r < ROWS; r++) begin
                rows_o[r] = (row_q == RW'(r));
            end
            cols_o = ~row_pat_q;
        end
    end

endmodule

// File: rtl/dice_matrix_scan_driver.sv
// Rolling-dice controller: roll/settle FSM and face register feeding a 3x3 pip scanner.
// Latency: load_i shows on value_o next cycle; faces reach the pins within one row period.
// Backpressure: none; load_i beats roll_i and any coincident roll step.
module dice_matrix_scan_driver
    import dice_led_pkg::*;
#(
    parameter int FACES        = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter int ROLL_STEP    = 50000,
    parameter int SETTLE_STEPS = 5,
    localparam int VW          = $clog2(FACES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          roll_i,
    input  logic          load_i,
    input  logic [VW-1:0] value_i,
    output logic [2:0]    rows_o,
    output logic [2:0]    cols_o,
    output logic [VW-1:0] value_o,
    output logic          rolling_o,
    output logic          settled_o
);

    localparam int SW  = $clog2(ROLL_STEP + 1);
    localparam int RMW = $clog2(SETTLE_STEPS + 1);
    localparam logic [VW-1:0] VMAX = VW'(FACES - 1);

    roll_state_t    state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [RMW-1:0] rem_q, rem_d;
    logic [VW-1:0]  value_q, value_d;
    logic           rolling_q;
    logic           settled_q, settled_d;
    logic           step_hit;
    logic [VW-1:0]  value_next;
    logic [VW-1:0]  value_clamped;
    logic [8:0]     pattern;

    assign step_hit      = (state_q != SHOW) && (step_q == SW'(ROLL_STEP - 1));
    assign value_next    = (value_q == VMAX) ? '0 : value_q + VW'(1);
    assign value_clamped = (value_i > VMAX) ? VMAX : value_i;
    assign pattern       = pips(4'(value_q));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rem_d     = rem_q;
        value_d   = value_q;
        settled_d = 1'b0;
        case (state_q)
            SHOW: begin
                step_d = '0;
                if (roll_i) begin
                    state_d = ROLL;
                end
            end
            ROLL: begin
                step_d = step_hit ? '0 : step_q + SW'(1);
                if (step_hit) begin
                    value_d = value_next;
                end
                // Step phase carries over into SETTLE so the animation cadence is unbroken.
                if (!roll_i) begin
                    state_d = SETTLE;
                    rem_d   = RMW'(SETTLE_STEPS);
                end
            end
            SETTLE: begin
                step_d = step_hit ? '0 : step_q + SW'(1);
                if (step_hit) begin
                    value_d = value_next;
                    rem_d   = rem_q - RMW'(1);
                end
                if (roll_i) begin
                    state_d = ROLL;
                end else if (step_hit && (rem_q == RMW'(1))) begin
                    state_d   = SHOW;
                    settled_d = 1'b1;
                end
            end
            default: begin
                state_d = SHOW;
            end
        endcase
        if (load_i) begin
            value_d   = value_clamped;
            state_d   = SHOW;
            step_d    = '0;
            settled_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SHOW;
            step_q    <= '0;
            rem_q     <= '0;
            value_q   <= '0;
            rolling_q <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            rem_q     <= rem_d;
            value_q   <= value_d;
            rolling_q <= (state_d != SHOW);
            settled_q <= settled_d;
        end
    end

    assign value_o   = value_q;
    assign rolling_o = rolling_q;
    assign settled_o = settled_q;

    led_matrix_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .pattern_i (pattern),
        .rows_o    (rows_o),
        .cols_o    (cols_o)
    );

endmodule
